// File: rtl/comb_decimator_seq.sv
// rtl/comb_decimator_seq.sv - word-serial decimating comb (differentiator) stage
//
// Purpose:
//   Takes multi-word samples presented LSB word first, keeps one sample out of
//   every `decimation`, and emits y[n] = x[n] - x[n-1] over the kept samples.
//   Precision beyond one word comes from a borrow passed from each word to the
//   next word of the same sample. The last borrow is dropped, so the result is
//   modulo 2^(word_length*latency), matching the upstream integrator.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   data_in      in   sample word, LSB word first
//   LSB_flag     in   marks the first (least-significant) word of a sample
//   hold         in   stall: input ignored, no state advances
//   data_out     out  registered difference word
//   out_valid    out  data_out carries a new difference word
//   out_LSB_flag out  data_out is the LSB word of an output sample
//   frame_err    out  sticky framing-violation flag

module comb_decimator_seq #(
  parameter int word_length = 8,
  parameter int latency     = 4,
  parameter int decimation  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [word_length-1:0] data_in,
  input  logic                   LSB_flag,
  input  logic                   hold,
  output logic [word_length-1:0] data_out,
  output logic                   out_valid,
  output logic                   out_LSB_flag,
  output logic                   frame_err
);

  localparam int CW = (latency > 1) ? $clog2(latency) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(latency - 1);
  localparam logic [7:0]    DEC_LAST = 8'(decimation - 1);

  logic [word_length-1:0] data_out_q, data_out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_lsb_q, out_lsb_d;
  logic                   frame_err_q, frame_err_d;
  logic [CW-1:0]          word_cnt_q, word_cnt_d;
  logic [7:0]             dec_cnt_q, dec_cnt_d;
  logic                   borrow_q, borrow_d;
  // First advance after reset: an LSB word there is not a framing error.
  logic                   first_q, first_d;
  // Keep decision latched at the LSB word, applied to the remaining words.
  logic                   keep_q, keep_d;
  logic [word_length-1:0] prev_q [latency];
  logic [word_length-1:0] prev_d [latency];

  logic [CW-1:0]          idx;
  logic                   keep_now;
  logic                   b_in;
  logic [word_length:0]   sub;

  always_comb begin
    // Word index for this advance; saturates when the LSB marker goes missing.
    if (LSB_flag) begin
      idx = '0;
    end else if (word_cnt_q == LAST_IDX) begin
      idx = LAST_IDX;
    end else begin
      idx = word_cnt_q + CW'(1);
    end

    keep_now = (idx == '0) ? (dec_cnt_q == 8'd0) : keep_q;
    b_in     = (idx == '0) ? 1'b0 : borrow_q;
    // One extra bit on top catches the borrow out of this word.
    sub      = {1'b0, data_in} - {1'b0, prev_q[idx]} - {{word_length{1'b0}}, b_in};

    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    out_lsb_d   = 1'b0;
    frame_err_d = frame_err_q;
    word_cnt_d  = word_cnt_q;
    dec_cnt_d   = dec_cnt_q;
    borrow_d    = borrow_q;
    first_d     = first_q;
    keep_d      = keep_q;
    prev_d      = prev_q;

    if (!hold) begin
      word_cnt_d = idx;
      first_d    = 1'b0;
      keep_d     = keep_now;

      if ((LSB_flag && (word_cnt_q != LAST_IDX) && !first_q) ||
          (!LSB_flag && (word_cnt_q == LAST_IDX))) begin
        frame_err_d = 1'b1;
      end

      if (idx == LAST_IDX) begin
        dec_cnt_d = (dec_cnt_q >= DEC_LAST) ? 8'd0 : dec_cnt_q + 8'd1;
      end

      if (keep_now) begin
        data_out_d   = sub[word_length-1:0];
        out_valid_d  = 1'b1;
        out_lsb_d    = (idx == '0);
        borrow_d     = sub[word_length];
        prev_d[idx]  = data_in;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_lsb_q   <= 1'b0;
      frame_err_q <= 1'b0;
      word_cnt_q  <= '0;
      dec_cnt_q   <= 8'd0;
      borrow_q    <= 1'b0;
      first_q     <= 1'b1;
      // A partial sample after reset is discarded until the next LSB word.
      keep_q      <= 1'b0;
      prev_q      <= '{default: '0};
    end else begin
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      out_lsb_q   <= out_lsb_d;
      frame_err_q <= frame_err_d;
      word_cnt_q  <= word_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      borrow_q    <= borrow_d;
      first_q     <= first_d;
      keep_q      <= keep_d;
      prev_q      <= prev_d;
    end
  end

  assign data_out     = data_out_q;
  assign out_valid    = out_valid_q;
  assign out_LSB_flag = out_lsb_q;
  assign frame_err    = frame_err_q;

endmodule
